// File: rtl/spell_mem_pkg.sv
// spell_mem_pkg: shared types and constants for the spell memory request path.
//   state_t      - request sequencer states (2-bit encoding)
//   MEM_ERR_DATA - read data returned when an access is aborted by the watchdog
//   GRANT_*      - identifies which requester owns the current access
//   pick_data    - round-robin grant decision between fetch and data ports
package spell_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] MEM_ERR_DATA = 8'hFF;
  localparam logic       GRANT_FETCH  = 1'b0;
  localparam logic       GRANT_DATA   = 1'b1;

  // Data wins a tie unless it won the previous grant, so neither port can
  // be starved by the other holding its request high.
  function automatic logic pick_data(input logic fetch_req, input logic data_req,
                                     input logic last_grant);
    pick_data = data_req && (!fetch_req || (last_grant != GRANT_DATA));
  endfunction

endpackage

// File: rtl/spell_mem_watchdog.sv
// spell_mem_watchdog: counts cycles an access has been waiting for the memory.
//   clock, reset - clock and synchronous active-high reset
//   clear        - restart the count (asserted when a new access is granted)
//   run          - count this cycle (access in progress, memory not ready)
//   expired      - count has reached TIMEOUT_CYCLES-1; never set when
//                  TIMEOUT_CYCLES is 0
// The counter saturates at the limit instead of wrapping.
module spell_mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam bit         ENABLED = (TIMEOUT_CYCLES != 0);
  localparam int         LIMIT_I = ENABLED ? int'(TIMEOUT_CYCLES) - 1 : 0;
  localparam logic [7:0] LIMIT   = 8'(LIMIT_I);

  logic [7:0] count_r;
  logic       at_limit_s;

  assign at_limit_s = ENABLED && (count_r == LIMIT);
  assign expired    = at_limit_s;

  // Wait-cycle counter, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (run && !at_limit_s && ENABLED) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/spell_mem_req.sv
// spell_mem_req: arbitrates the core's fetch and data ports onto spell_mem.
//   clock, reset          - clock and synchronous active-high reset
//   fetch_req/addr        - code read request (level, held until fetch_done)
//   fetch_data/done       - registered code byte and one-cycle completion pulse
//   data_req/addr/wdata/write - data load/store request (level)
//   data_rdata/done       - registered load result and completion pulse
//   mem_select/addr/data_in/type_data/write - registered request to spell_mem,
//                           held stable for the whole access
//   mem_data_out/data_ready - response from spell_mem
//   timeout_err           - sticky flag, set when the watchdog aborts an access
module spell_mem_req
  import spell_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic [7:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       fetch_done,
  input  logic       data_req,
  input  logic [7:0] data_addr,
  input  logic [7:0] data_wdata,
  input  logic       data_write,
  output logic [7:0] data_rdata,
  output logic       data_done,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic       mem_type_data,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,
  output logic       timeout_err
);

  state_t     state_r, state_s;
  logic       last_grant_r, last_grant_s;
  logic       mem_select_s, mem_type_data_s, mem_write_s;
  logic [7:0] mem_addr_s, mem_data_in_s;
  logic [7:0] fetch_data_s, data_rdata_s, cap_s;
  logic       fetch_done_s, data_done_s, timeout_err_s;
  logic       wd_clear_s, wd_run_s, wd_expired_s;

  // The watchdog only advances while an access is waiting on the memory.
  assign wd_run_s = (state_r == ACCESS) && !mem_data_ready;

  spell_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear_s),
    .run    (wd_run_s),
    .expired(wd_expired_s)
  );

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_s         = state_r;
    last_grant_s    = last_grant_r;
    mem_select_s    = mem_select;
    mem_addr_s      = mem_addr;
    mem_data_in_s   = mem_data_in;
    mem_type_data_s = mem_type_data;
    mem_write_s     = mem_write;
    fetch_data_s    = fetch_data;
    data_rdata_s    = data_rdata;
    fetch_done_s    = 1'b0;
    data_done_s     = 1'b0;
    timeout_err_s   = timeout_err;
    wd_clear_s      = 1'b0;
    cap_s           = 8'h00;

    case (state_r)
      IDLE: begin
        if (fetch_req || data_req) begin
          state_s      = ACCESS;
          mem_select_s = 1'b1;
          wd_clear_s   = 1'b1;
          if (pick_data(fetch_req, data_req, last_grant_r)) begin
            last_grant_s    = GRANT_DATA;
            mem_addr_s      = data_addr;
            mem_data_in_s   = data_wdata;
            mem_write_s     = data_write;
            mem_type_data_s = 1'b1;
          end else begin
            last_grant_s    = GRANT_FETCH;
            mem_addr_s      = fetch_addr;
            mem_data_in_s   = 8'h00;
            mem_write_s     = 1'b0;
            mem_type_data_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ACCESS: begin
        // Ready takes priority over an expiring watchdog in the same cycle.
        if (mem_data_ready || wd_expired_s) begin
          state_s      = DONE;
          mem_select_s = 1'b0;
          if (mem_data_ready) begin
            cap_s = mem_data_out;
          end else begin
            cap_s         = MEM_ERR_DATA;
            timeout_err_s = 1'b1;
          end
          // mem_type_data identifies the owning port for this access.
          if (mem_type_data == GRANT_DATA) begin
            data_done_s = 1'b1;
            if (!mem_write) begin
              data_rdata_s = cap_s;
            end else begin
              data_rdata_s = data_rdata;
            end
          end else begin
            fetch_done_s = 1'b1;
            fetch_data_s = cap_s;
          end
        end else begin
          state_s = ACCESS;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s      = IDLE;
        mem_select_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      last_grant_r  <= GRANT_FETCH;
      mem_select    <= 1'b0;
      mem_addr      <= 8'h00;
      mem_data_in   <= 8'h00;
      mem_type_data <= 1'b0;
      mem_write     <= 1'b0;
      fetch_data    <= 8'h00;
      data_rdata    <= 8'h00;
      fetch_done    <= 1'b0;
      data_done     <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_r       <= state_s;
      last_grant_r  <= last_grant_s;
      mem_select    <= mem_select_s;
      mem_addr      <= mem_addr_s;
      mem_data_in   <= mem_data_in_s;
      mem_type_data <= mem_type_data_s;
      mem_write     <= mem_write_s;
      fetch_data    <= fetch_data_s;
      data_rdata    <= data_rdata_s;
      fetch_done    <= fetch_done_s;
      data_done     <= data_done_s;
      timeout_err   <= timeout_err_s;
    end
  end

endmodule

// File: tb/tb_spell_mem_req.sv
module tb_spell_mem_req;

  logic       clock;
  logic       reset;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       fetch_done;
  logic       data_req;
  logic [7:0] data_addr;
  logic [7:0] data_wdata;
  logic       data_write;
  logic [7:0] data_rdata;
  logic       data_done;
  logic       mem_select;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_type_data;
  logic       mem_write;
  logic [7:0] mem_data_out;
  logic       mem_data_ready;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  spell_mem_req #(.TIMEOUT_CYCLES(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_data    (fetch_data),
    .fetch_done    (fetch_done),
    .data_req      (data_req),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_write    (data_write),
    .data_rdata    (data_rdata),
    .data_done     (data_done),
    .mem_select    (mem_select),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_type_data (mem_type_data),
    .mem_write     (mem_write),
    .mem_data_out  (mem_data_out),
    .mem_data_ready(mem_data_ready),
    .timeout_err   (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       f_req;
    logic [7:0] f_addr;
    logic       d_req;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_wr;
    logic [7:0] m_dout;
    logic       m_rdy;
    logic       e_sel;
    logic [7:0] e_addr;
    logic [7:0] e_din;
    logic       e_type;
    logic       e_wr;
    logic       e_fdone;
    logic [7:0] e_fdata;
    logic       e_ddone;
    logic [7:0] e_drdata;
    logic       e_terr;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = 8'h00;
    data_req = 1'b0; data_addr = 8'h00; data_wdata = 8'h00; data_write = 1'b0;
    mem_data_out = 8'h00; mem_data_ready = 1'b0;

    //          rst  freq fadr   dreq dadr   dwd    dwr  dout   rdy   sel  addr   din    typ  wr   fd   fdat   dd   drd    te
    vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0};
    // fetch read, memory ready in the first ACCESS cycle (ready in IDLE ignored)
    vecs[1]  = '{1'b0,1'b1,8'h10,1'b0,8'h00,8'h00,1'b0,8'hA5,1'b1, 1'b1,8'h10,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0};
    vecs[2]  = '{1'b0,1'b1,8'h10,1'b0,8'h00,8'h00,1'b0,8'hA5,1'b1, 1'b0,8'h10,8'h00,1'b0,1'b0,1'b1,8'hA5,1'b0,8'h00,1'b0};
    vecs[3]  = '{1'b0,1'b0,8'h10,1'b0,8'h00,8'h00,1'b0,8'hA5,1'b0, 1'b0,8'h10,8'h00,1'b0,1'b0,1'b0,8'hA5,1'b0,8'h00,1'b0};
    // data store, ready after 4 ACCESS cycles, inputs wiggled meanwhile
    vecs[4]  = '{1'b0,1'b0,8'h00,1'b1,8'h62,8'h3C,1'b1,8'h00,1'b0, 1'b1,8'h62,8'h3C,1'b1,1'b1,1'b0,8'hA5,1'b0,8'h00,1'b0};
    vecs[5]  = '{1'b0,1'b0,8'h00,1'b1,8'h99,8'h11,1'b0,8'h00,1'b0, 1'b1,8'h62,8'h3C,1'b1,1'b1,1'b0,8'hA5,1'b0,8'h00,1'b0};
    vecs[6]  = '{1'b0,1'b0,8'h00,1'b1,8'h99,8'h11,1'b0,8'h00,1'b0, 1'b1,8'h62,8'h3C,1'b1,1'b1,1'b0,8'hA5,1'b0,8'h00,1'b0};
    vecs[7]  = '{1'b0,1'b0,8'h00,1'b1,8'h99,8'h11,1'b0,8'h00,1'b0, 1'b1,8'h62,8'h3C,1'b1,1'b1,1'b0,8'hA5,1'b0,8'h00,1'b0};
    vecs[8]  = '{1'b0,1'b0,8'h00,1'b1,8'h99,8'h11,1'b0,8'h00,1'b0, 1'b1,8'h62,8'h3C,1'b1,1'b1,1'b0,8'hA5,1'b0,8'h00,1'b0};
    vecs[9]  = '{1'b0,1'b0,8'h00,1'b1,8'h99,8'h11,1'b0,8'h77,1'b1, 1'b0,8'h62,8'h3C,1'b1,1'b1,1'b0,8'hA5,1'b1,8'h00,1'b0};
    vecs[10] = '{1'b0,1'b0,8'h00,1'b0,8'h99,8'h11,1'b0,8'h00,1'b0, 1'b0,8'h62,8'h3C,1'b1,1'b1,1'b0,8'hA5,1'b0,8'h00,1'b0};
    // data load
    vecs[11] = '{1'b0,1'b0,8'h00,1'b1,8'h20,8'h55,1'b0,8'h00,1'b0, 1'b1,8'h20,8'h55,1'b1,1'b0,1'b0,8'hA5,1'b0,8'h00,1'b0};
    vecs[12] = '{1'b0,1'b0,8'h00,1'b1,8'h20,8'h55,1'b0,8'h5A,1'b1, 1'b0,8'h20,8'h55,1'b1,1'b0,1'b0,8'hA5,1'b1,8'h5A,1'b0};
    // ready in DONE and in IDLE with no request is ignored
    vecs[13] = '{1'b0,1'b0,8'h00,1'b0,8'h20,8'h55,1'b0,8'h5A,1'b1, 1'b0,8'h20,8'h55,1'b1,1'b0,1'b0,8'hA5,1'b0,8'h5A,1'b0};
    vecs[14] = '{1'b0,1'b0,8'h00,1'b0,8'h20,8'h55,1'b0,8'h5A,1'b1, 1'b0,8'h20,8'h55,1'b1,1'b0,1'b0,8'hA5,1'b0,8'h5A,1'b0};

    for (int i = 0; i < 15; i++) begin
      reset = vecs[i].rst; fetch_req = vecs[i].f_req; fetch_addr = vecs[i].f_addr;
      data_req = vecs[i].d_req; data_addr = vecs[i].d_addr; data_wdata = vecs[i].d_wdata;
      data_write = vecs[i].d_wr; mem_data_out = vecs[i].m_dout; mem_data_ready = vecs[i].m_rdy;
      tick();
      chk($sformatf("row%0d_select", i), {7'd0, mem_select}, {7'd0, vecs[i].e_sel});
      chk($sformatf("row%0d_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("row%0d_data_in", i), mem_data_in, vecs[i].e_din);
      chk($sformatf("row%0d_type", i), {7'd0, mem_type_data}, {7'd0, vecs[i].e_type});
      chk($sformatf("row%0d_write", i), {7'd0, mem_write}, {7'd0, vecs[i].e_wr});
      chk($sformatf("row%0d_fetch_done", i), {7'd0, fetch_done}, {7'd0, vecs[i].e_fdone});
      chk($sformatf("row%0d_fetch_data", i), fetch_data, vecs[i].e_fdata);
      chk($sformatf("row%0d_data_done", i), {7'd0, data_done}, {7'd0, vecs[i].e_ddone});
      chk($sformatf("row%0d_data_rdata", i), data_rdata, vecs[i].e_drdata);
      chk($sformatf("row%0d_timeout_err", i), {7'd0, timeout_err}, {7'd0, vecs[i].e_terr});
    end

    // Contention: both requests held high, grants alternate data/fetch.
    mem_data_ready = 1'b0; data_req = 1'b0; fetch_req = 1'b0;
    pulse_reset();
    fetch_req = 1'b1; fetch_addr = 8'hF0;
    data_req = 1'b1; data_addr = 8'hD0; data_wdata = 8'h00; data_write = 1'b0;
    mem_data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_data;
      exp_data = (i % 2 == 0);
      mem_data_out = 8'hC0 + 8'(i);
      tick();
      chk($sformatf("arb%0d_select", i), {7'd0, mem_select}, 8'h01);
      chk($sformatf("arb%0d_type", i), {7'd0, mem_type_data}, {7'd0, exp_data});
      chk($sformatf("arb%0d_addr", i), mem_addr, exp_data ? 8'hD0 : 8'hF0);
      tick();
      chk($sformatf("arb%0d_data_done", i), {7'd0, data_done}, {7'd0, exp_data});
      chk($sformatf("arb%0d_fetch_done", i), {7'd0, fetch_done}, {7'd0, !exp_data});
      if (exp_data) begin
        chk($sformatf("arb%0d_rdata", i), data_rdata, 8'hC0 + 8'(i));
      end else begin
        chk($sformatf("arb%0d_fdata", i), fetch_data, 8'hC0 + 8'(i));
      end
      tick();
      chk($sformatf("arb%0d_idle_select", i), {7'd0, mem_select}, 8'h00);
    end

    // Timeout: load that never sees ready aborts after 8 ACCESS cycles.
    fetch_req = 1'b0; data_req = 1'b0; mem_data_ready = 1'b0;
    pulse_reset();
    data_req = 1'b1; data_addr = 8'h33; data_write = 1'b0;
    tick();
    chk("to_grant_select", {7'd0, mem_select}, 8'h01);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("to_wait%0d_done", k), {7'd0, data_done}, 8'h00);
      chk($sformatf("to_wait%0d_select", k), {7'd0, mem_select}, 8'h01);
    end
    tick();
    chk("to_done", {7'd0, data_done}, 8'h01);
    chk("to_rdata", data_rdata, 8'hFF);
    chk("to_err", {7'd0, timeout_err}, 8'h01);
    chk("to_select", {7'd0, mem_select}, 8'h00);
    data_req = 1'b0;
    tick();
    fetch_req = 1'b1; fetch_addr = 8'h12; mem_data_out = 8'h12; mem_data_ready = 1'b1;
    tick();
    tick();
    chk("to_after_fetch_done", {7'd0, fetch_done}, 8'h01);
    chk("to_after_fetch_data", fetch_data, 8'h12);
    chk("to_err_sticky", {7'd0, timeout_err}, 8'h01);
    fetch_req = 1'b0; mem_data_ready = 1'b0;
    tick();

    // Ready in the same cycle the watchdog expires: normal completion.
    pulse_reset();
    chk("exp_err_cleared", {7'd0, timeout_err}, 8'h00);
    data_req = 1'b1; data_addr = 8'h44; data_write = 1'b0;
    tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("exp_wait%0d_done", k), {7'd0, data_done}, 8'h00);
    end
    mem_data_ready = 1'b1; mem_data_out = 8'h42;
    tick();
    chk("exp_done", {7'd0, data_done}, 8'h01);
    chk("exp_rdata", data_rdata, 8'h42);
    chk("exp_no_err", {7'd0, timeout_err}, 8'h00);
    data_req = 1'b0; mem_data_ready = 1'b0;
    tick();

    // Reset two cycles into an access.
    fetch_req = 1'b1; fetch_addr = 8'h55;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_select", {7'd0, mem_select}, 8'h00);
    chk("rst_fetch_done", {7'd0, fetch_done}, 8'h00);
    chk("rst_data_rdata", data_rdata, 8'h00);
    chk("rst_addr", mem_addr, 8'h00);
    reset = 1'b0; fetch_req = 1'b0;
    tick();
    chk("rst_idle_select", {7'd0, mem_select}, 8'h00);
    chk("rst_idle_done", {7'd0, fetch_done}, 8'h00);
    fetch_req = 1'b1; fetch_addr = 8'h66; mem_data_out = 8'h9C; mem_data_ready = 1'b1;
    tick();
    chk("rst_fresh_select", {7'd0, mem_select}, 8'h01);
    chk("rst_fresh_addr", mem_addr, 8'h66);
    tick();
    chk("rst_fresh_done", {7'd0, fetch_done}, 8'h01);
    chk("rst_fresh_data", fetch_data, 8'h9C);
    fetch_req = 1'b0; mem_data_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spell_mem_req.md
Name: spell_mem_req

Overview:
Request sequencer directly upstream of the spell memory mux (spell_mem). It arbitrates between the core's instruction-fetch port and data load/store port, registers the winning request and holds select/addr/data/type/write stable until the memory asserts data_ready. It then returns read data with a one-cycle done pulse. A watchdog aborts accesses that never complete, for example when the SRAM ack is lost.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ACCESS before abort; 0 disables the watchdog; legal range 0..255.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_req  in  1  code read request; level, held until fetch_done
fetch_addr  in  8  code address
fetch_data  out  8  registered code byte
fetch_done  out  1  one-cycle completion pulse
data_req  in  1  data access request; level, held until data_done
data_addr  in  8  data address
data_wdata  in  8  write data
data_write  in  1  1 = store, 0 = load
data_rdata  out  8  registered load result
data_done  out  1  one-cycle completion pulse
mem_select  out  1  to spell_mem select
mem_addr  out  8  to spell_mem addr
mem_data_in  out  8  to spell_mem data_in
mem_type_data  out  1  0 = code space, 1 = data space
mem_write  out  1  to spell_mem write
mem_data_out  in  8  from spell_mem data_out
mem_data_ready  in  1  from spell_mem data_ready
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clocking and reset: a single clock domain on `clock`. `reset` is synchronous and active-high.
- Reset values: state IDLE; every output is 0, including fetch_data, data_rdata, both done pulses, all mem_* outputs and timeout_err; last_grant = fetch.
- States: IDLE, ACCESS, DONE. Encoding is 2 bits.
- IDLE: if exactly one req is high, grant it. If both are high, grant data unless last_grant == data, in which case grant fetch (round-robin anti-starvation).
  - On grant, at the next edge: latch addr, wdata, write and type into the mem_* registers; set mem_select = 1; clear the watchdog count; update last_grant; move to ACCESS.
  - For a fetch grant: mem_type_data = 0, mem_write = 0, mem_data_in = 0.
- ACCESS: all mem_* outputs are held constant.
  - If mem_data_ready is high: at the next edge, if the access was a read, capture mem_data_out into the granted port's rdata register; pulse that port's done; set mem_select = 0; move to DONE.
  - On a write, data_rdata is unchanged.
  - Otherwise the watchdog increments. When count == TIMEOUT_CYCLES - 1 (TIMEOUT_CYCLES != 0): abort exactly as on ready, but load rdata = 8'hFF (reads only) and set timeout_err = 1.
- Simultaneous events: if mem_data_ready is high in the same cycle the watchdog expires, ready wins (normal completion, no error).
- DONE: done is high for this cycle only. Move to IDLE unconditionally. Requesters drop req on the edge ending DONE, so IDLE never re-grants a completed request.
- Latency: req seen in IDLE at cycle 0 → mem_select high in cycle 1. If mem_data_ready is high in cycle k ≥ 1, done and rdata are valid in cycle k+1. Minimum turnaround is 3 cycles per access.
- mem_data_ready is ignored in IDLE and DONE.
- Changes to req/addr/wdata while a request is in ACCESS have no effect.
- timeout_err is cleared only by reset.
- Reset mid-operation: at the reset edge, state returns to IDLE and mem_select drops. No done pulse is produced and rdata is cleared.
- Watchdog counter is 8 bits and never wraps; it is compared and stops at the limit.

Decomposition:
- Shared package spell_mem_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - MEM_ERR_DATA = 8'hFF
  - GRANT_FETCH / GRANT_DATA constants
- One natural sub-module: spell_mem_watchdog.
  - Inputs: clock, reset, clear, run.
  - Output: expired.
  - Parameterised by TIMEOUT_CYCLES.

Test Plan:
- Fetch read, memory ready in same cycle as select (dff-like): fetch_req=1, fetch_addr=8'h10, mem_data_out=8'hA5 → mem_select=1 in cycle 1 with mem_addr=8'h10 and mem_type_data=0; fetch_done=1 and fetch_data=8'hA5 in cycle 2; mem_select=0 in cycle 2.
- Data store with SRAM-style delay: data_req=1, data_write=1, data_addr=8'h62, data_wdata=8'h3C, ready asserted 4 cycles after select → mem_write=1, mem_type_data=1, inputs held stable for all 4 cycles; data_done exactly 1 cycle after ready; data_rdata unchanged.
- Contention: both reqs high continuously → grants alternate data, fetch, data, fetch. Neither port waits more than one other access.
- Timeout with TIMEOUT_CYCLES=8: data load, ready never asserted → data_done after 8 ACCESS cycles; data_rdata=8'hFF; timeout_err=1 and it stays high through later successful accesses.
- Ready on the expiry cycle: mem_data_ready=1 in the 8th ACCESS cycle with mem_data_out=8'h42 → data_rdata=8'h42 and timeout_err stays 0.
- Reset during ACCESS: assert reset for 1 cycle 2 cycles into an access → next cycle mem_select=0, no done pulse, state IDLE. A fresh request afterwards completes normally.
